// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, imem req/ack handshake, IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection with a HALT state.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h80020000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_fetch_count,
  output logic        o_fetch_misaligned
);

  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_fetch_count;
  logic        w_run;
  logic        w_accept;
  logic [31:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;
  state_t r_state;
  logic   r_misaligned;

  assign w_run              = (r_state == ST_RUN);
  assign w_target           = i_branch_target;
  assign o_fetch_misaligned = r_misaligned;
`else
  assign w_run              = 1'b1;
  assign w_target           = i_branch_target & 32'hFFFF_FFFC;
  assign o_fetch_misaligned = 1'b0;
`endif

  // A held (stalled) instruction blocks new requests; reset drops the request at once.
  assign o_imem_req  = w_run && !i_reset && !(i_stall && r_if_valid);
  assign o_imem_addr = r_pc;
  assign w_accept    = o_imem_req && i_imem_ack && !i_branch_taken;

  // PC, IF/ID register and counter; priority: reset, redirect, accept, stall-hold, bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0000_0000;
      r_if_instr    <= 32'h0000_0000;
      r_fetch_count <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      r_state       <= ST_RUN;
      r_misaligned  <= 1'b0;
`endif
    end else if (i_branch_taken && w_run) begin
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_target[1:0] != 2'b00) begin
        r_misaligned <= 1'b1;
        r_state      <= ST_HALT;
      end else begin
        r_state      <= ST_RUN;
      end
`endif
    end else if (w_accept) begin
      r_if_pc    <= r_pc;
      r_if_instr <= i_imem_data;
      r_if_valid <= 1'b1;
      r_pc       <= r_pc + 32'd4;
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_fetch_count <= r_fetch_count;
      end
    end else if (i_stall && r_if_valid) begin
      r_if_valid <= r_if_valid;
    end else begin
      r_if_valid <= 1'b0;
    end
  end

  assign o_if_valid    = r_if_valid;
  assign o_if_pc       = r_if_pc;
  assign o_if_instr    = r_if_instr;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed plan steps plus randomized traffic vs a reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br, ack;
  logic [31:0] tgt, data;
  logic        o_imem_req, o_if_valid, o_fetch_misaligned;
  logic [31:0] o_imem_addr, o_if_pc, o_if_instr, o_fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_ifpc, m_ifinstr, m_count;
  logic        m_valid, m_halt, m_mis;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_branch_taken(br),
    .i_branch_target(tgt), .i_imem_ack(ack), .i_imem_data(data),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .o_if_valid(o_if_valid),
    .o_if_pc(o_if_pc), .o_if_instr(o_if_instr), .o_fetch_count(o_fetch_count),
    .o_fetch_misaligned(o_fetch_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h80020000; m_valid = 1'b0; m_ifpc = 32'h0; m_ifinstr = 32'h0;
    m_count = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
  endtask

  // One clock: drive inputs, check request side, advance model, check registered side.
  task automatic cyc(input logic rs, input logic st, input logic b, input logic [31:0] t, input logic a);
    logic mreq, acc;
    reset = rs; stall = st; br = b; tgt = t; ack = a; data = m_pc ^ 32'hA5A5A5A5;
    #1;
    mreq = !rs && !m_halt && !(st && m_valid);
    chk("imem_req", {31'h0, o_imem_req}, {31'h0, mreq});
    chk("imem_addr", o_imem_addr, m_pc);
    acc = mreq && a && !b;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (b && !m_halt) begin
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = t;
      if (t[1:0] != 2'b00) begin m_mis = 1'b1; m_halt = 1'b1; end
`else
      m_pc = {t[31:2], 2'b00};
`endif
      m_valid = 1'b0;
    end else if (acc) begin
      m_ifpc = m_pc; m_ifinstr = data; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      if (m_count != 32'hFFFFFFFF) m_count = m_count + 32'd1;
    end else if (!(st && m_valid)) begin
      m_valid = 1'b0;
    end
    #1;
    chk("if_valid", {31'h0, o_if_valid}, {31'h0, m_valid});
    chk("if_pc", o_if_pc, m_ifpc);
    chk("if_instr", o_if_instr, m_ifinstr);
    chk("fetch_count", o_fetch_count, m_count);
    chk("misaligned", {31'h0, o_fetch_misaligned}, {31'h0, m_mis});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; ack = 1'b0; data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_req", {31'h0, o_imem_req}, 32'h0);
    chk("reset_addr", o_imem_addr, 32'h80020000);
    chk("reset_valid", {31'h0, o_if_valid}, 32'h0);
    chk("reset_if_pc", o_if_pc, 32'h0);
    chk("reset_count", o_fetch_count, 32'h0);

    // Streaming with constant ack
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("count5", o_fetch_count, 32'd5);
    chk("stream_if_pc", o_if_pc, 32'h80020010);
    chk("stream_instr", o_if_instr, 32'h80020010 ^ 32'hA5A5A5A5);

    // Reset mid-request, then ack gap at 0x80020008
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("gap_addr", o_imem_addr, 32'h80020008);
    chk("gap_valid", {31'h0, o_if_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("gap_if_pc", o_if_pc, 32'h80020008);

    // Stall with a live instruction
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_if_pc", o_if_pc, 32'h80020008);
    chk("stall_addr", o_imem_addr, 32'h8002000C);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("resume_if_pc", o_if_pc, 32'h8002000C);

    // Redirect in the same cycle as an ack
    cyc(1'b0, 1'b0, 1'b1, 32'h80020100, 1'b1);
    chk("br_addr", o_imem_addr, 32'h80020100);
    chk("br_valid", {31'h0, o_if_valid}, 32'h0);
    chk("br_count", o_fetch_count, 32'd4);

    // Redirect while stalled, then PC wrap
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_if_pc0", o_if_pc, 32'hFFFFFFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_if_pc1", o_if_pc, 32'h00000000);
    chk("wrap_addr", o_imem_addr, 32'h00000004);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      rt[1:0] = 2'b00;
`endif
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), rt, ($urandom_range(0, 3) != 0));
    end

    // Misaligned redirect
    cyc(1'b0, 1'b0, 1'b1, 32'h80020102, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", {31'h0, o_fetch_misaligned}, 32'h1);
    chk("mis_req", {31'h0, o_imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h80020200, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_addr", o_imem_addr, 32'h80020102);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_cleared", {31'h0, o_fetch_misaligned}, 32'h0);
`else
    chk("mis_addr", o_imem_addr, 32'h80020100);
    chk("mis_flag", {31'h0, o_fetch_misaligned}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the pipeline. Holds the program counter and issues word requests to instruction memory over a req/ack handshake. Registers each returned instruction with its PC into the IF/ID boundary, and applies decode stalls and execute-stage branch redirects. Its PC path sits directly upstream of the 32-bit next-PC/operand 2:1 selection in decode.

## Interface
- RESET_PC, 32'h80020000, PC loaded on reset
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept a new instruction this cycle
- branch_taken  in  1  redirect request from execute
- branch_target  in  32  redirect address
- imem_ack  in  1  memory returns data this cycle; meaningful only while imem_req=1
- imem_data  in  32  instruction word, valid with imem_ack
- imem_req  out  1  fetch request (combinational from state)
- imem_addr  out  32  fetch address, equals pc
- if_valid  out  1  if_pc/if_instr hold a live instruction
- if_pc  out  32  PC of registered instruction
- if_instr  out  32  registered instruction
- fetch_count  out  32  accepted-instruction count, saturating
- fetch_misaligned  out  1  sticky misalignment flag (see Configuration; constant 0 otherwise)

## Operation
- States: RUN, HALT (HALT exists only with the macro).
- Reset: state=RUN, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fetch_count=0, fetch_misaligned=0. imem_req=0 while reset=1.
- imem_req = (state==RUN) && !reset && !(stall && if_valid). imem_addr = pc at all times.
- Accept = imem_req && imem_ack && !branch_taken.
- Priority per cycle, highest first: reset, branch_taken, accept, stall-hold, bubble.
- branch_taken=1:
  - pc <= branch_target; if_valid <= 0.
  - Any same-cycle ack is discarded and not counted.
  - Takes effect even while stall=1.
  - The outstanding request is abandoned; memory restarts on the new address.
- Accept:
  - if_pc <= pc; if_instr <= imem_data; if_valid <= 1.
  - pc <= pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - fetch_count increments, saturating at 0xFFFFFFFF.
- stall=1 with if_valid=1: if_valid, if_pc, if_instr and pc all hold; no request is issued.
- stall=1 with if_valid=0: fetch proceeds normally to fill the register.
- stall=0 with no accept: if_valid <= 0, because decode consumed the previous instruction. if_pc/if_instr keep their last values.
- No ack while req=1: pc and imem_addr stay stable until ack or redirect.

## Timing
- Request is issued in the first cycle after reset deasserts.
- Ack in cycle N: if_valid/if_pc/if_instr update at edge N→N+1, and imem_addr=pc+4 in cycle N+1.
- Throughput is one instruction per cycle with single-cycle ack.
- Redirect in cycle N: imem_addr=branch_target in N+1, and if_valid=0 in N+1.
- Reset asserted mid-request: the request drops the same cycle (combinational), and all state is reset at the next edge.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with branch_target[1:0]≠0 sets fetch_misaligned=1 (sticky), loads pc=branch_target unmodified, and enters HALT.
  - In HALT, imem_req=0, if_valid=0, and further redirects are ignored until reset.
- FETCH_ALIGN_CHECK_EN undefined:
  - branch_target[1:0] is forced to 2'b00 on load.
  - fetch_misaligned is tied to 0; no HALT state exists.

## Test plan
- Reset, then imem_ack=1 constantly, with imem_data=addr^32'hA5A5A5A5 -> imem_addr reads 0x80020000, 0x80020004, … each cycle; if_pc trails imem_addr by one cycle; if_valid=1 from cycle 2; fetch_count=5 after 5 accepts.
- imem_ack low for 3 cycles at 0x80020008 -> imem_addr held at 0x80020008 and if_valid=0 for those cycles; on ack, if_pc=0x80020008 next cycle.
- stall=1 for 2 cycles with if_valid=1 -> imem_req=0; if_pc/if_instr/pc unchanged; release resumes at the held pc.
- branch_taken=1 with branch_target=0x80020100 in the same cycle as imem_ack -> next cycle if_valid=0, imem_addr=0x80020100; fetch_count not incremented.
- Redirect to 0xFFFFFFFC, then ack twice -> if_pc=0xFFFFFFFC, then if_pc=0x00000000.
- branch_target=0x80020102:
  - With FETCH_ALIGN_CHECK_EN: fetch_misaligned=1, imem_req=0 until reset.
  - Without it: imem_addr=0x80020100.
